// File: rtl/speed_mult_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// speed_pkg
// Shared Q-format constants and helpers for the phase-to-speed datapath.
//   PHASE_W / FRAC : phase-average word (9Q10), signed
//   SPEED_W        : speed output word, signed
//   SCALE_DEFAULT  : nominal phase-to-speed scale coefficient
//   sat_slice()    : arithmetic right shift + saturating narrow to out_w bits
// No ports (package).
// -----------------------------------------------------------------------------
package speed_pkg;

  localparam int PHASE_W       = 19;
  localparam int SPEED_W       = 16;
  localparam int FRAC          = 10;
  localparam int SCALE_DEFAULT = 20450;

  // value holds the narrowed result sign-extended to 32 bits; callers keep
  // the low out_w bits.
  typedef struct packed {
    logic        sat;
    logic [31:0] value;
  } slice_t;

  // Shift p right arithmetically (truncation toward minus infinity), then
  // clamp to the signed out_w range. Out-of-range is exactly the case where
  // the bits above the kept slice are not a pure sign extension.
  function automatic slice_t sat_slice(input logic signed [63:0] p,
                                       input int shift,
                                       input int out_w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    slice_t r;
    s       = p >>> shift;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (out_w - 1));
    r.sat   = 1'b0;
    r.value = s[31:0];
    if (s > hi) begin
      r.sat   = 1'b1;
      r.value = hi[31:0];
    end else if (s < lo) begin
      r.sat   = 1'b1;
      r.value = lo[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/speed_mult_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered one-hot grant pulse.
//   i_clk       : rising-edge clock
//   i_rst       : asynchronous active-high reset (pointer -> 0, grant -> 0)
//   i_req       : per-requester request level
//   o_gnt       : registered one-hot grant, high for one cycle
//   o_sel_idx   : index being granted at the coming edge (combinational)
//   o_sel_valid : a grant will be issued at the coming edge
// A requester currently showing a grant is not eligible in that cycle, so a
// held request is never granted twice in a row on the same operands.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_sel_idx,
  output logic            o_sel_valid
);

  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;

  logic [NREQ-1:0] w_elig;
  logic            w_hit_hi;
  logic            w_hit_lo;
  logic [IW-1:0]   w_idx_hi;
  logic [IW-1:0]   w_idx_lo;

  assign w_elig = i_req & ~r_gnt;

  // Two searches in one descending loop: the lowest eligible index at or
  // above the pointer, and the lowest eligible index overall (the wrap case).
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_elig[j]) begin
        w_hit_lo = 1'b1;
        w_idx_lo = IW'(j);
        if (j >= int'(r_ptr)) begin
          w_hit_hi = 1'b1;
          w_idx_hi = IW'(j);
        end
      end
    end
  end

  assign o_sel_valid = w_hit_lo;
  assign o_sel_idx   = w_hit_hi ? w_idx_hi : w_idx_lo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_gnt <= '0;
    end else begin
      r_gnt <= '0;
      if (o_sel_valid) begin
        r_gnt[o_sel_idx] <= 1'b1;
        r_ptr <= (o_sel_idx == IW'(NREQ - 1)) ? '0 : o_sel_idx + 1'b1;
      end
    end
  end

  assign o_gnt = r_gnt;

endmodule

// File: rtl/speed_mult_arbiter.sv
// -----------------------------------------------------------------------------
// speed_mult_arbiter
// One signed scaling multiplier shared round-robin among NREQ requesters.
// Each grant captures that requester's operands; the product comes back LAT
// cycles later, shifted, saturated to OUT_W bits and tagged one-hot.
//   i_clock     : rising-edge clock
//   i_reset     : asynchronous active-high reset; drops all in-flight ops
//   i_req       : per-requester request level
//   i_op_a      : flattened operand A, requester i at [i*A_W +: A_W]
//   i_op_b      : flattened operand B, requester i at [i*B_W +: B_W]
//   o_gnt       : one-hot grant pulse; operands sampled on its rising edge
//   o_res_valid : one-hot result tag pulse
//   o_result    : shared result bus, holds its value between results
//   o_sat       : result was clamped (only while o_res_valid != 0)
//   o_busy      : some pipeline stage holds a valid op
// -----------------------------------------------------------------------------
module speed_mult_arbiter
  import speed_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int A_W   = PHASE_W,
  parameter int B_W   = 16,
  parameter int OUT_W = SPEED_W,
  parameter int SHIFT = 12,
  parameter int LAT   = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*A_W-1:0] i_op_a,
  input  logic [NREQ*B_W-1:0] i_op_b,
  output logic [NREQ-1:0]     o_gnt,
  output logic [NREQ-1:0]     o_res_valid,
  output logic [OUT_W-1:0]    o_result,
  output logic                o_sat,
  output logic                o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = A_W + B_W;

  genvar gi;

  // Unpack the flattened operand buses so the grant index can select them.
  logic [A_W-1:0] w_a_arr [NREQ];
  logic [B_W-1:0] w_b_arr [NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = i_op_a[gi*A_W +: A_W];
      assign w_b_arr[gi] = i_op_b[gi*B_W +: B_W];
    end
  endgenerate

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_sel_idx;
  logic            w_sel_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_clk       (i_clock),
    .i_rst       (i_reset),
    .i_req       (i_req),
    .o_gnt       (w_gnt),
    .o_sel_idx   (w_sel_idx),
    .o_sel_valid (w_sel_valid)
  );

  assign o_gnt = w_gnt;

  // Stage 1: operands, loaded on the same edge that raises the grant. The
  // registered grant itself serves as this stage's tag.
  logic signed [A_W-1:0] r_a;
  logic signed [B_W-1:0] r_b;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_sel_valid) begin
      r_a <= w_a_arr[w_sel_idx];
      r_b <= w_b_arr[w_sel_idx];
    end
  end

  logic signed [PW-1:0] w_prod;
  assign w_prod = r_a * r_b;

  // Entry 0 is the combinational product of stage 1; entries 1..LAT-1 are
  // registered product stages. The output register retires entry LAT-1, so
  // the result lands exactly LAT edges after the grant edge.
  logic [LAT-1:0][PW-1:0]   w_p_chain;
  logic [LAT-1:0][NREQ-1:0] w_tag_chain;

  assign w_p_chain[0]   = w_prod;
  assign w_tag_chain[0] = w_gnt;

  generate
    for (gi = 1; gi < LAT; gi++) begin : g_pipe
      logic [PW-1:0]   r_p;
      logic [NREQ-1:0] r_tag;
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_p   <= '0;
          r_tag <= '0;
        end else begin
          r_p   <= w_p_chain[gi-1];
          r_tag <= w_tag_chain[gi-1];
        end
      end
      assign w_p_chain[gi]   = r_p;
      assign w_tag_chain[gi] = r_tag;
    end
  endgenerate

  assign o_busy = |w_tag_chain;

  // Saturating narrow of the last product stage.
  logic signed [63:0] w_p_ext;
  slice_t             w_slice;
  logic               w_unused_slice_hi;

  assign w_p_ext           = {{(64-PW){w_p_chain[LAT-1][PW-1]}}, w_p_chain[LAT-1]};
  assign w_slice           = sat_slice(w_p_ext, SHIFT, OUT_W);
  assign w_unused_slice_hi = ^w_slice.value[31:OUT_W];

  logic [NREQ-1:0]  r_res_valid;
  logic [OUT_W-1:0] r_result;
  logic             r_sat;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_res_valid <= '0;
      r_result    <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_res_valid <= w_tag_chain[LAT-1];
      if (|w_tag_chain[LAT-1]) begin
        r_result <= w_slice.value[OUT_W-1:0];
        r_sat    <= w_slice.sat;
      end else begin
        r_sat    <= 1'b0;
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_result    = r_result;
  assign o_sat       = r_sat;

endmodule

// File: tb/tb_speed_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_speed_mult_arbiter
// Self-checking bench: a constant vector table of single operations, then
// hand-written multi-requester sequences. Every grant pushes an expected
// result onto a scoreboard queue; a negedge monitor pops and compares it.
// -----------------------------------------------------------------------------
module tb_speed_mult_arbiter;

  localparam int NREQ  = 4;
  localparam int A_W   = 19;
  localparam int B_W   = 16;
  localparam int OUT_W = 16;
  localparam int SHIFT = 12;
  localparam int LAT   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*A_W-1:0] op_a = '0;
  logic [NREQ*B_W-1:0] op_b = '0;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     res_valid;
  logic [OUT_W-1:0]    result;
  logic                sat;
  logic                busy;

  speed_mult_arbiter #(
    .NREQ (NREQ), .A_W (A_W), .B_W (B_W),
    .OUT_W(OUT_W), .SHIFT(SHIFT), .LAT(LAT)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_gnt       (gnt),
    .o_res_valid (res_valid),
    .o_result    (result),
    .o_sat       (sat),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NREQ-1:0]  tag;
    logic [OUT_W-1:0] res;
    logic             sat;
    int               cyc;
  } sb_t;

  typedef struct {
    int               idx;
    int               a;
    int               b;
    logic [OUT_W-1:0] res;
    logic             sat;
  } vec_t;

  sb_t              sb[$];
  sb_t              mon_e;
  logic [OUT_W-1:0] last_result = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [A_W-1:0] get_a(input int idx);
    return op_a[idx*A_W +: A_W];
  endfunction

  function automatic logic signed [B_W-1:0] get_b(input int idx);
    return op_b[idx*B_W +: B_W];
  endfunction

  task automatic set_op(input int idx, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    op_a[idx*A_W +: A_W] = a;
    op_b[idx*B_W +: B_W] = b;
  endtask

  task automatic rand_op(input int idx);
    set_op(idx, A_W'($urandom), B_W'($urandom));
  endtask

  // Reference: exact 64-bit product, floor shift, clamp to 16-bit signed.
  function automatic sb_t model(input int idx, input logic signed [A_W-1:0] a,
                                input logic signed [B_W-1:0] b, input int c);
    sb_t    e;
    longint p;
    longint q;
    p     = longint'(a) * longint'(b);
    q     = p >>> SHIFT;
    e.tag = NREQ'(1) << idx;
    e.cyc = c;
    if (q > 64'sd32767) begin
      e.res = 16'h7FFF;
      e.sat = 1'b1;
    end else if (q < -64'sd32768) begin
      e.res = 16'h8000;
      e.sat = 1'b1;
    end else begin
      e.res = q[15:0];
      e.sat = 1'b0;
    end
    return e;
  endfunction

  // Result monitor: every res_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid != '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got tag 0x%0h result 0x%0h required no result", res_valid, result);
        end else begin
          mon_e = sb.pop_front();
          chk("res_tag", res_valid, mon_e.tag);
          chk("res_value", result, mon_e.res);
          chk("res_sat", sat, mon_e.sat);
          chk("res_latency", cyc - mon_e.cyc, LAT);
          $display("txn tag=%b result=0x%04h sat=%0d expected=0x%04h/%0d", res_valid, result, sat, mon_e.res, mon_e.sat);
        end
        last_result = result;
      end else begin
        chk("idle_sat", sat, 1'b0);
        chk("idle_hold", result, last_result);
      end
    end
  end

  // One clock: compare the grant, queue the product for whoever was granted
  // and give that requester fresh operands in its grant cycle.
  task automatic step_check(input logic [NREQ-1:0] exp_g, input string nm);
    @(posedge clk); #1;
    chk(nm, gnt, exp_g);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sb.push_back(model(i, get_a(i), get_b(i), cyc));
        rand_op(i);
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    chk("drain_empty", sb.size(), 0);
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_result = '0;
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  vec_t            tv[12];
  logic [NREQ-1:0] oh;
  sb_t             e;

  initial begin
    tv[0]  = '{0,    1024, 20450, 16'h13F8, 1'b0};
    tv[1]  = '{2,   -1024, 20450, 16'hEC07, 1'b0};
    tv[2]  = '{1,  262143, 32767, 16'h7FFF, 1'b1};
    tv[3]  = '{3, -262144, 32767, 16'h8000, 1'b1};
    tv[4]  = '{0,   32767,  4096, 16'h7FFF, 1'b0};
    tv[5]  = '{1,   32768,  4096, 16'h7FFF, 1'b1};
    tv[6]  = '{2,  -32768,  4096, 16'h8000, 1'b0};
    tv[7]  = '{3,  -32769,  4096, 16'h8000, 1'b1};
    tv[8]  = '{0,       0, -32768, 16'h0000, 1'b0};
    tv[9]  = '{1,    4096,    -1, 16'hFFFF, 1'b0};
    tv[10] = '{3,      -1,     1, 16'hFFFF, 1'b0};
    tv[11] = '{2,    4095,     1, 16'h0000, 1'b0};

    // Reset state.
    #12;
    chk("reset_gnt", gnt, '0);
    chk("reset_res_valid", res_valid, '0);
    chk("reset_result", result, '0);
    chk("reset_sat", sat, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: single operations, back to back on alternating requesters.
    for (int v = 0; v < 12; v++) begin
      oh = NREQ'(1) << tv[v].idx;
      set_op(tv[v].idx, A_W'(tv[v].a), B_W'(tv[v].b));
      req = oh;
      @(posedge clk); #1;
      chk("vec_gnt", gnt, oh);
      chk("vec_busy", busy, 1'b1);
      if (gnt == oh) begin
        e.tag = oh;
        e.res = tv[v].res;
        e.sat = tv[v].sat;
        e.cyc = cyc;
        sb.push_back(e);
      end
      req = '0;
    end
    step_check(4'b0000, "vec_gnt_pulse");
    drain();

    // Round robin from pointer 0 with all four requesting.
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_op(i);
    req = 4'b1111;
    step_check(4'b0001, "rr_gnt0");
    step_check(4'b0010, "rr_gnt1");
    step_check(4'b0100, "rr_gnt2");
    step_check(4'b1000, "rr_gnt3");
    step_check(4'b0001, "rr_gnt0_wrap");
    req = '0;
    drain();

    // A lone held requester is granted every other cycle.
    rand_op(0);
    req = 4'b0001;
    step_check(4'b0001, "lone_gnt_a");
    step_check(4'b0000, "lone_excluded_a");
    step_check(4'b0001, "lone_gnt_b");
    step_check(4'b0000, "lone_excluded_b");
    step_check(4'b0001, "lone_gnt_c");
    req = '0;
    drain();

    // Fairness after the pointer has moved past requester 0.
    do_reset();
    rand_op(0);
    req = 4'b0001;
    step_check(4'b0001, "fair_first0");
    rand_op(1);
    rand_op(3);
    req = 4'b1010;
    step_check(4'b0010, "fair_gnt1_a");
    step_check(4'b1000, "fair_gnt3_a");
    step_check(4'b0010, "fair_gnt1_b");
    step_check(4'b1000, "fair_gnt3_b");
    req[0] = 1'b1;
    step_check(4'b0001, "fair_late0");
    step_check(4'b0010, "fair_gnt1_c");
    req = '0;
    step_check(4'b0000, "fair_idle");
    drain();

    // Reset in the cycle after a grant: the op must vanish.
    @(posedge clk); #1;
    set_op(0, A_W'(1024), B_W'(20450));
    req = 4'b0001;
    @(posedge clk); #1;
    chk("rstmid_gnt0", gnt, 4'b0001);
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_result = '0;
    sb.delete();
    #1;
    chk("rstmid_res_valid", res_valid, '0);
    chk("rstmid_result", result, '0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_gnt", gnt, '0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_busy_after", busy, 1'b0);
    rand_op(0);
    rand_op(1);
    req = 4'b0011;
    step_check(4'b0001, "rstmid_regrant0");
    req = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speed_mult_arbiter.md
Name: speed_mult_arbiter

Overview:
- Shares one signed scaling multiplier among NREQ requesters, such as per-channel phase-to-speed converters, each needing one avg x scale_factor product per averaging window.
- Round-robin arbitration, one grant per cycle, fixed-latency pipelined multiply.
- Result is truncated and saturated to a 6Q10-style output word, returned with a one-hot tag.
- Sits between the phase-averaging stages and the speed output registers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- A_W, 19, operand A width, signed (9Q10 phase average).
- B_W, 16, operand B width, signed (scale coefficient).
- OUT_W, 16, result width, signed.
- SHIFT, 12, right shift applied to the full product before slicing.
- LAT, 2, cycles from grant to res_valid (1..4).

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- req, in, NREQ, per-requester request level.
- op_a, in, NREQ*A_W, flattened operand A; requester i occupies [i*A_W +: A_W].
- op_b, in, NREQ*B_W, flattened operand B; requester i occupies [i*B_W +: B_W].
- gnt, out, NREQ, one-hot grant pulse; operands are captured this cycle.
- res_valid, out, NREQ, one-hot result-valid pulse (tag).
- result, out, OUT_W, shared result bus; valid only while res_valid != 0.
- sat, out, 1, saturation flag qualified by res_valid.
- busy, out, 1, high while any pipeline stage holds a valid op.

Behaviour:
- Reset (async assert, sync-released use):
  - gnt, res_valid, result, sat, busy all 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Pipeline valid bits cleared.
- Handshake:
  - A requester raises req[i] and holds op_a/op_b stable until it sees gnt[i].
  - gnt is registered: it asserts the cycle after arbitration and lasts exactly 1 cycle.
  - Operands are sampled on the clock edge that asserts gnt[i].
  - Dropping req before a grant is legal and has no effect.
  - Holding req after a grant requests another op. The requester must update its operands in the gnt cycle or accept a repeat product.
- Arbitration:
  - Each cycle, pick the first set req bit searching from pointer upward with wrap-around.
  - A requester currently showing gnt is excluded that cycle. This prevents a double grant of the same stale operands.
  - On grant, pointer = granted index + 1 (mod NREQ).
  - A lone requester holding req is granted every other cycle (grant, excluded, grant, ...).
  - Two or more active requesters give full throughput: one grant per cycle.
- Datapath:
  - Stage 1 registers a, b and the tag.
  - Stage 2 and later register the full signed product P = a*b (A_W+B_W bits), with the tag shifted alongside.
  - res_valid[tag], result and sat update together exactly LAT cycles after the gnt edge.
- Arithmetic:
  - Slice = P[SHIFT+OUT_W-1:SHIFT], i.e. arithmetic shift with truncation toward minus infinity.
  - If bits P[top:SHIFT+OUT_W-1] are not all equal, clamp to +(2^(OUT_W-1)-1) or -2^(OUT_W-1) according to P's sign, and set sat=1.
  - Otherwise sat=0.
- result holds its last value when res_valid=0; sat is cleared.
- busy = OR of all pipeline valid bits.
- Simultaneous events: a new grant and a result retire in the same cycle independently; there is no stall path, so the pipeline always advances.
- Reset mid-operation clears the pipeline. In-flight ops are dropped and their res_valid never asserts; requesters must re-request.

Decomposition:
- Shared package speed_pkg holds:
  - Q-format constants (PHASE_W=19, SPEED_W=16, FRAC=10).
  - Default SCALE constant 20450.
  - A saturating slice function sat_slice(P, SHIFT, OUT_W) returning {sat, value}.
- One sub-module is natural: rr_arbiter (NREQ request vector in, one-hot grant plus index out, pointer register inside), reusable elsewhere.
- The multiplier pipeline stays inline.

Test Plan:
- Single op: req0=1, a=1024, b=20450 -> gnt=0001 for 1 cycle; 2 cycles later res_valid=0001, result=5112 (16'h13F8), sat=0.
- Negative truncation: req2, a=-1024, b=20450 -> res_valid=0100, result=-5113 (16'hEC07), sat=0.
- Saturation: a=262143, b=32767 -> result=32767 (16'h7FFF), sat=1. Then a=-262144, b=32767 -> result=-32768 (16'h8000), sat=1.
- Round robin: req=1111 held with distinct operands -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles. Each res_valid tag matches its gnt, LAT=2 later, with the correct product.
- Fairness after pointer move: last grant was 0, then req=1010 held -> gnt 0010,1000,0010,1000. Requester 0 raising req mid-sequence is served before requester 1's next turn only if the pointer has passed 3.
- Reset mid-op: reset asserted the cycle after gnt0 -> no res_valid pulse, result=0, busy=0. After release, req0 regrants at pointer 0.
